// File: rtl/program_loader.sv
// Boot-time loader: assembles a framed little-endian byte stream (word count + words) into program-memory writes.
// Latency: one registered write strobe in the cycle after the edge that accepts byte 3 of each word.
// Backpressure: none needed; in_ready = busy and it takes one byte every cycle while HEADER/DATA.
//
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   start                  - one-cycle pulse; re-arms a load from any state
//   in_data/in_valid/in_ready - byte stream handshake (in_ready from state only)
//   mem_we/mem_address/mem_data - registered single-cycle word write to program memory
//   busy/done/error        - load status; done/error held until the next start
module program_loader #(
    parameter int PROGRAM_MEMORY_ADDRESS_BITWIDTH = 16,
    parameter int PROGRAM_MEMORY_SIZE_BYTE        = 65536
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       start,
    input  logic [7:0]                                 in_data,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    output logic                                       mem_we,
    output logic [PROGRAM_MEMORY_ADDRESS_BITWIDTH-1:0] mem_address,
    output logic [31:0]                                mem_data,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       error
);

    localparam int          AW       = PROGRAM_MEMORY_ADDRESS_BITWIDTH;
    localparam int          WIW      = AW - 1;
    localparam logic [31:0] WORD_CAP = 32'(PROGRAM_MEMORY_SIZE_BYTE / 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     byte_idx_q, byte_idx_d;
    logic [WIW-1:0] word_idx_q, word_idx_d;
    logic [31:0]    count_q, count_d;
    logic [23:0]    wbuf_q, wbuf_d;      // bytes 0..2 of the word being assembled
    logic           mem_we_q, mem_we_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]    mem_data_q, mem_data_d;

    logic           busy_w;
    logic           accept;
    logic [31:0]    count_full;
    logic [31:0]    word_next;

    assign busy_w     = (state_q == S_HEADER) || (state_q == S_DATA);
    assign accept     = in_valid && busy_w;
    // Header value as it stands once the current byte is folded in as byte 3.
    assign count_full = {in_data, count_q[23:0]};
    // Compared against the full 32-bit count so oversize headers can never alias.
    assign word_next  = 32'(word_idx_q) + 32'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            wbuf_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            wbuf_q     <= wbuf_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        wbuf_d     = wbuf_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        if (start) begin
            // start wins over a byte accepted in the same cycle; that byte is dropped.
            state_d    = S_HEADER;
            byte_idx_d = '0;
            word_idx_d = '0;
            count_d    = '0;
            wbuf_d     = '0;
        end else if (accept) begin
            byte_idx_d = byte_idx_q + 2'd1;   // wraps 3 -> 0
            if (state_q == S_HEADER) begin
                case (byte_idx_q)
                    2'd0: count_d[7:0]   = in_data;
                    2'd1: count_d[15:8]  = in_data;
                    2'd2: count_d[23:16] = in_data;
                    default: begin
                        count_d = count_full;
                        if (count_full == 32'd0) begin
                            state_d = S_DONE;
                        end else if (count_full > WORD_CAP) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                endcase
            end else begin
                case (byte_idx_q)
                    2'd0: wbuf_d[7:0]   = in_data;
                    2'd1: wbuf_d[15:8]  = in_data;
                    2'd2: wbuf_d[23:16] = in_data;
                    default: begin
                        mem_we_d   = 1'b1;
                        mem_data_d = {in_data, wbuf_q};
                        // Index of a written word is below the word capacity, so it fits AW-2 bits.
                        mem_addr_d = {word_idx_q[AW-3:0], 2'b00};
                        word_idx_d = word_next[WIW-1:0];
                        if (word_next == count_q) begin
                            state_d = S_DONE;
                        end
                    end
                endcase
            end
        end
    end

    assign busy        = busy_w;
    assign in_ready    = busy_w;
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERROR);
    assign mem_we      = mem_we_q;
    assign mem_address = mem_addr_q;
    assign mem_data    = mem_data_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_address;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic        error;

    program_loader #(
        .PROGRAM_MEMORY_ADDRESS_BITWIDTH(16),
        .PROGRAM_MEMORY_SIZE_BYTE       (65536)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tid;
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [15:0] addr;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] h_addr;
    logic [31:0] h_data;
    int          cur_tid;
    int          errors;
    int          checks;

    // Appends one vector; address/data expectations follow the last write (held while mem_we=0).
    task automatic push(input logic st, input logic v, input logic [7:0] d,
                        input logic rdy, input logic bsy, input logic dn, input logic er,
                        input logic we, input logic [15:0] wa, input logic [31:0] wd);
        vec_t x;
        if (we) begin
            h_addr = wa;
            h_data = wd;
        end
        x.tid = cur_tid; x.st = st; x.v = v; x.d = d;
        x.rdy = rdy; x.we = we; x.addr = h_addr; x.data = h_data;
        x.busy = bsy; x.done = dn; x.err = er;
        vecs.push_back(x);
    endtask

    task automatic do_start();
        push(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    task automatic busy_byte(input logic [7:0] d);
        push(1'b0, 1'b1, d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    task automatic idle_busy();
        push(1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic [15:0] a, input logic [31:0] w,
                           input logic last);
        if (last) push(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, a, w);
        else      push(1'b0, 1'b1, d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a, w);
    endtask

    task automatic check(input string name, input logic rdy, input logic we,
                         input logic [15:0] addr, input logic [31:0] data,
                         input logic bsy, input logic dn, input logic er);
        checks++;
        if ({in_ready, mem_we, mem_address, mem_data, busy, done, error} !==
            {rdy, we, addr, data, bsy, dn, er}) begin
            errors++;
            $display("FAIL %s got rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b, want rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b",
                     name, in_ready, mem_we, mem_address, mem_data, busy, done, error,
                     rdy, we, addr, data, bsy, dn, er);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic [7:0] d);
        @(negedge clk);
        start = st; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] s2 [12];
        logic [7:0] hdr1 [4];
        errors  = 0;
        checks  = 0;
        h_addr  = '0;
        h_data  = '0;
        reset_n = 1'b0;
        start   = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;

        // Test 1: two-word load back-to-back.
        cur_tid = 1;
        do_start();
        busy_byte(8'h02); busy_byte(8'h00); busy_byte(8'h00); busy_byte(8'h00);
        busy_byte(8'h13); busy_byte(8'h00); busy_byte(8'h00);
        wr_byte(8'h00, 16'h0000, 32'h0000_0013, 1'b0);
        busy_byte(8'h93); busy_byte(8'h00); busy_byte(8'h10);
        wr_byte(8'h00, 16'h0004, 32'h0010_0093, 1'b1);
        push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        push(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);

        // Test 2: same stream with an idle cycle before every byte.
        cur_tid = 2;
        s2 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00};
        do_start();
        for (int i = 0; i < 12; i++) begin
            idle_busy();
            if (i == 7)       wr_byte(s2[i], 16'h0000, 32'h0000_0013, 1'b0);
            else if (i == 11) wr_byte(s2[i], 16'h0004, 32'h0010_0093, 1'b1);
            else              busy_byte(s2[i]);
        end
        push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);

        // Test 3: zero-length header completes with no writes.
        cur_tid = 3;
        do_start();
        busy_byte(8'h00); busy_byte(8'h00); busy_byte(8'h00);
        push(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        push(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0);

        // Test 4: 16385 words exceeds 16384-word capacity.
        cur_tid = 4;
        do_start();
        busy_byte(8'h01); busy_byte(8'h40); busy_byte(8'h00);
        push(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0);
        push(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0);

        // Test 5: restart mid-word; the byte arriving with start is dropped too.
        cur_tid = 5;
        do_start();
        busy_byte(8'h02); busy_byte(8'h00); busy_byte(8'h00); busy_byte(8'h00);
        busy_byte(8'h11); busy_byte(8'h22);
        push(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        busy_byte(8'h01); busy_byte(8'h00); busy_byte(8'h00); busy_byte(8'h00);
        busy_byte(8'hEF); busy_byte(8'hBE); busy_byte(8'hAD);
        wr_byte(8'hDE, 16'h0000, 32'hDEAD_BEEF, 1'b1);

        // Reset state.
        #12;
        check("reset_state", 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 8'h77);
        check("idle_no_accept", 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].v, vecs[i].d);
            check($sformatf("vec t%0d#%0d", vecs[i].tid, i), vecs[i].rdy, vecs[i].we,
                  vecs[i].addr, vecs[i].data, vecs[i].busy, vecs[i].done, vecs[i].err);
        end

        // Test 6: asynchronous reset in the middle of a data word.
        hdr1 = '{8'h01, 8'h00, 8'h00, 8'h00};
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, hdr1[i]);
        drive(1'b0, 1'b1, 8'h11);
        drive(1'b0, 1'b1, 8'h22);
        check("mid_data_busy", 1'b1, 1'b0, 16'h0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h33;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_immediate", 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b1, 8'h44);
        check("post_reset_idle_1", 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h55);
        check("post_reset_idle_2", 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h00);
        check("post_reset_start", 1'b1, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time writer for the instruction store. It accepts a byte stream (typically from the UART receiver) framed as a 4-byte little-endian word count followed by that many 32-bit little-endian instruction words. It assembles each word and issues one single-cycle write per word into program memory at consecutive word-aligned byte addresses starting at 0. Once loading is done, it signals completion so the core can be released from reset and begin fetching.

## Interface
Parameters:
- PROGRAM_MEMORY_ADDRESS_BITWIDTH, default 16: byte-address width of program memory.
- PROGRAM_MEMORY_SIZE_BYTE, default 65536: capacity in bytes; word capacity is this value / 4.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; arms a new load from any state.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  write strobe to program memory, one cycle per word.
- mem_address  output  PROGRAM_MEMORY_ADDRESS_BITWIDTH  byte address; bits [1:0] are always 0.
- mem_data  output  32  word to write.
- busy  output  1  high in HEADER and DATA states.
- done  output  1  load completed successfully; held until next start.
- error  output  1  header count exceeds capacity; held until next start.

## Operation
- A byte is accepted on a rising edge where in_valid && in_ready.
- in_ready = busy. It is combinational from state only, never from in_valid.
- States:
  - IDLE: after reset.
  - HEADER: collecting 4 count bytes.
  - DATA: collecting words.
  - DONE.
  - ERROR.
- start in any state:
  - next state is HEADER;
  - byte index, word index and count are cleared;
  - done and error are cleared;
  - any partially assembled word is discarded.
- start has priority over a byte accepted in the same cycle; that byte is dropped.
- HEADER: byte i (i = 0..3) goes to count[8i+7:8i]. On acceptance of byte 3:
  - count == 0: go to DONE.
  - count > PROGRAM_MEMORY_SIZE_BYTE/4: go to ERROR.
  - otherwise: go to DATA.
- DATA: byte i goes to word[8i+7:8i]. On acceptance of byte 3:
  - register mem_we=1, mem_data={byte3,byte2,byte1,byte0}, mem_address=word_index<<2;
  - increment word_index;
  - if word_index+1 == count, go to DONE.
- Byte index wraps 3→0 after each completed word or header.
- Once the final word has been written (DONE reached), the address never exceeds the last word. count is compared as a 32-bit value; word_index is PROGRAM_MEMORY_ADDRESS_BITWIDTH-1 bits wide, enough to hold the word capacity.
- DONE and ERROR: in_ready=0 and the loader writes nothing; extra stream bytes are left unconsumed.
- Reset mid-load: the load is abandoned, state returns to IDLE, and memory contents are untouched.

## Timing
- Reset values:
  - state IDLE;
  - in_ready, mem_we, busy, done, error = 0;
  - mem_address = 0, mem_data = 0.
- mem_we, mem_address, mem_data are registered:
  - The write is visible in the cycle immediately after the edge that accepted byte 3 of a word.
  - mem_we is high for exactly 1 cycle per word; mem_address/mem_data hold their value when mem_we=0.
- The loader needs no backpressure: it can accept one byte every cycle, so the maximum write rate is one word per 4 cycles.
- done/error rise in the cycle after the edge that accepted the final byte; busy falls in that same cycle.
- For a nonzero load, the last mem_we pulse and the rise of done are in the same cycle.
- start → in_ready=1 in the following cycle.

## Test plan
- Reset, then start; feed header 02 00 00 00, then bytes 13 00 00 00 / 93 00 10 00 back-to-back -> writes (0x0, 0x00000013) then (0x4, 0x00100093), one cycle each; done=1 and busy=0 in the same cycle as the second write.
- Same stream with in_valid toggled every other cycle -> identical writes and addresses; no write on idle cycles.
- Header 00 00 00 00 -> no mem_we; done=1 one cycle after the 4th header byte.
- Header 01 40 00 00 (16385 > 16384 words) -> error=1, done=0, in_ready=0, no writes.
- start after 2 bytes of the first data word, then header 01 00 00 00 and word EF BE AD DE -> single write (0x0, 0xDEADBEEF); the earlier partial bytes are not used.
- Assert reset_n=0 asynchronously mid-DATA -> all outputs 0 immediately, state IDLE, in_ready=0 until the next start.
